// File: rtl/glitch_pkg.sv
// Shared definitions for the glitch trigger path: FSM state encoding and default widths.
package glitch_pkg;

  localparam int CNT_W_DEF       = 24;
  localparam int PW_W_DEF        = 8;
  localparam int REP_W_DEF       = 8;
  localparam int SYNC_STAGES_DEF = 2;
  localparam int TO_W_DEF        = 32;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_ARMED = 3'd1;
  localparam logic [2:0] ST_DELAY = 3'd2;
  localparam logic [2:0] ST_PULSE = 3'd3;
  localparam logic [2:0] ST_GAP   = 3'd4;
  localparam logic [2:0] ST_DONE  = 3'd5;

  typedef enum logic [2:0] {
    IDLE  = ST_IDLE,
    ARMED = ST_ARMED,
    DELAY = ST_DELAY,
    PULSE = ST_PULSE,
    GAP   = ST_GAP,
    DONE  = ST_DONE
  } state_e;

endpackage

// File: rtl/glitch_trigger_delay_if.sv
// Software/target-facing bundle of the trigger delay: arm/abort control, config, target event, status.
interface glitch_trigger_delay_if
  import glitch_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF,
  parameter int PW_W  = PW_W_DEF,
  parameter int REP_W = REP_W_DEF,
  parameter int TO_W  = TO_W_DEF
);

  logic             arm;
  logic             abort;
  logic             ext_trig;
  logic             edge_sel;
  logic [CNT_W-1:0] cfg_delay;
  logic [PW_W-1:0]  cfg_width;
  logic [REP_W-1:0] cfg_repeat;
  logic [CNT_W-1:0] cfg_gap;
  logic [TO_W-1:0]  cfg_timeout;
  logic             trig;
  logic             armed;
  logic             busy;
  logic             done;
  logic             timed_out;

  modport master (
    output arm, abort, ext_trig, edge_sel,
    output cfg_delay, cfg_width, cfg_repeat, cfg_gap, cfg_timeout,
    input  trig, armed, busy, done, timed_out
  );

  modport slave (
    input  arm, abort, ext_trig, edge_sel,
    input  cfg_delay, cfg_width, cfg_repeat, cfg_gap, cfg_timeout,
    output trig, armed, busy, done, timed_out
  );

endinterface

// File: rtl/sync_edge_detect.sv
// Synchronises an async level into clk and flags one selected edge (rising or falling).
// edge_o is combinational from the last sync flop and one history flop: SYNC_STAGES cycles after the input moves.
module sync_edge_detect #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic async_i,
  input  logic fall_i,
  output logic edge_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic                   lvl;

  assign lvl = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], async_i};
      prev_q <= lvl;
    end
  end

  assign edge_o = fall_i ? (prev_q & ~lvl) : (~prev_q & lvl);

endmodule

// File: rtl/glitch_trigger_delay.sv
// Armed target-event delay and trig burst generator; all status/trig outputs are flops of next state.
// First trig rises cfg_delay+1 cycles after the synchronised edge; ARMED timeout exists only with GLITCH_TRIG_TIMEOUT_EN.
module glitch_trigger_delay
  import glitch_pkg::*;
#(
  parameter int CNT_W       = CNT_W_DEF,
  parameter int PW_W        = PW_W_DEF,
  parameter int REP_W       = REP_W_DEF,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int TO_W        = TO_W_DEF
) (
  input logic                   clk,
  input logic                   rst,
  glitch_trigger_delay_if.slave bus
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [REP_W-1:0] rep_q, rep_d;
  logic [CNT_W-1:0] dly_q;
  logic [CNT_W-1:0] gap_m1_q;
  logic [PW_W-1:0]  wid_m1_q;
  logic             sel_q;
  logic             edge_det;
  logic             arm_take;
  logic             to_hit;
  logic             trig_q, armed_q, busy_q, done_q, timed_out_q;

  sync_edge_detect #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync_edge (
    .clk    (clk),
    .rst    (rst),
    .async_i(bus.ext_trig),
    .fall_i (sel_q),
    .edge_o (edge_det)
  );

  assign arm_take = (state_q == IDLE) && bus.arm && !bus.abort;

`ifdef GLITCH_TRIG_TIMEOUT_EN
  logic [TO_W-1:0] tcnt_q, tcnt_d;
  logic            to_en_q;
`else
  logic [TO_W-1:0] unused_timeout;
  assign unused_timeout = bus.cfg_timeout;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rep_d   = rep_q;
    to_hit  = 1'b0;
`ifdef GLITCH_TRIG_TIMEOUT_EN
    tcnt_d  = tcnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.arm) state_d = ARMED;
      end
      ARMED: begin
        // An edge in the timeout cycle takes priority over the timeout.
        if (edge_det) begin
          if (dly_q == '0) begin
            state_d = PULSE;
            cnt_d   = CNT_W'(wid_m1_q);
          end else begin
            state_d = DELAY;
            cnt_d   = dly_q - CNT_W'(1);
          end
        end
`ifdef GLITCH_TRIG_TIMEOUT_EN
        else if (to_en_q && (tcnt_q == '0)) begin
          state_d = IDLE;
          to_hit  = 1'b1;
        end else begin
          tcnt_d = tcnt_q - TO_W'(1);
        end
`endif
      end
      DELAY: begin
        if (cnt_q == '0) begin
          state_d = PULSE;
          cnt_d   = CNT_W'(wid_m1_q);
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      PULSE: begin
        if (cnt_q == '0) begin
          if (rep_q != '0) begin
            state_d = GAP;
            cnt_d   = gap_m1_q;
            rep_d   = rep_q - REP_W'(1);
          end else begin
            state_d = DONE;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      GAP: begin
        if (cnt_q == '0) begin
          state_d = PULSE;
          cnt_d   = CNT_W'(wid_m1_q);
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (bus.abort) begin
      state_d = IDLE;
      to_hit  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      rep_q       <= '0;
      dly_q       <= '0;
      gap_m1_q    <= '0;
      wid_m1_q    <= '0;
      sel_q       <= 1'b0;
      trig_q      <= 1'b0;
      armed_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      timed_out_q <= 1'b0;
`ifdef GLITCH_TRIG_TIMEOUT_EN
      tcnt_q      <= '0;
      to_en_q     <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rep_q       <= rep_d;
      trig_q      <= (state_d == PULSE);
      armed_q     <= (state_d == ARMED);
      busy_q      <= (state_d inside {DELAY, PULSE, GAP});
      done_q      <= (state_d == DONE);
      timed_out_q <= to_hit;
`ifdef GLITCH_TRIG_TIMEOUT_EN
      tcnt_q      <= tcnt_d;
`endif
      // Zero-valued width/repeat/gap behave as one; store them pre-decremented.
      if (arm_take) begin
        dly_q    <= bus.cfg_delay;
        wid_m1_q <= (bus.cfg_width == '0) ? '0 : bus.cfg_width - PW_W'(1);
        gap_m1_q <= (bus.cfg_gap == '0) ? '0 : bus.cfg_gap - CNT_W'(1);
        rep_q    <= (bus.cfg_repeat == '0) ? '0 : bus.cfg_repeat - REP_W'(1);
        sel_q    <= bus.edge_sel;
`ifdef GLITCH_TRIG_TIMEOUT_EN
        tcnt_q   <= bus.cfg_timeout - TO_W'(1);
        to_en_q  <= (bus.cfg_timeout != '0);
`endif
      end
    end
  end

  assign bus.trig      = trig_q;
  assign bus.armed     = armed_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.timed_out = timed_out_q;

endmodule

// File: tb/tb_glitch_trigger_delay.sv
// Bench for glitch_trigger_delay: directed scenarios plus random bursts against a timeline model.
module tb_glitch_trigger_delay;
  import glitch_pkg::*;

  localparam int S = SYNC_STAGES_DEF;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  glitch_trigger_delay_if bus_if ();

  glitch_trigger_delay dut (
    .clk(clk),
    .rst(rst),
    .bus(bus_if)
  );

  int errors = 0;
  int checks = 0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int k, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cycle %0d: observed %b expected %b", tag, k, obs, exp);
    end
  endtask

  task automatic chk_all(input int k, input logic e_trig, input logic e_armed,
                         input logic e_busy, input logic e_done, input logic e_to);
    chk("trig", k, bus_if.trig, e_trig);
    chk("armed", k, bus_if.armed, e_armed);
    chk("busy", k, bus_if.busy, e_busy);
    chk("done", k, bus_if.done, e_done);
    chk("timed_out", k, bus_if.timed_out, e_to);
  endtask

  task automatic scramble_cfg();
    bus_if.cfg_delay   = CNT_W_DEF'($urandom);
    bus_if.cfg_width   = PW_W_DEF'($urandom);
    bus_if.cfg_repeat  = REP_W_DEF'($urandom);
    bus_if.cfg_gap     = CNT_W_DEF'($urandom);
    bus_if.cfg_timeout = TO_W_DEF'($urandom_range(1, 3));
    bus_if.edge_sel    = 1'($urandom);
  endtask

  // Expected waveform from the rules: first trig at t0+1+delay, pulses of width we
  // separated by ge low cycles, done right after the last pulse; all quiet after an abort.
  task automatic run_burst(input int d, input int w, input int r, input int g,
                           input bit sel, input bit wrong_first,
                           input int ab_rel, input bit use_rst, input int tmo);
    int  we, re, ge, c1, c, t0, tfirst, tdone, ab, kend;
    bit  l0, live;
    logic e_trig, e_armed, e_busy, e_done;
    we = (w == 0) ? 1 : w;
    re = (r == 0) ? 1 : r;
    ge = (g == 0) ? 1 : g;
    l0 = wrong_first ? ~sel : sel;

    // Both edge directions occur while idle and must be dropped.
    bus_if.ext_trig = l0;
    repeat (3) step();
    bus_if.ext_trig = ~l0;
    repeat (3) step();
    bus_if.ext_trig = l0;
    repeat (S + 3) step();
    chk_all(0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    bus_if.cfg_delay   = CNT_W_DEF'(d);
    bus_if.cfg_width   = PW_W_DEF'(w);
    bus_if.cfg_repeat  = REP_W_DEF'(r);
    bus_if.cfg_gap     = CNT_W_DEF'(g);
    bus_if.cfg_timeout = TO_W_DEF'(tmo);
    bus_if.edge_sel    = sel;
    bus_if.arm         = 1'b1;

    c1     = 2 + int'($urandom_range(0, 3));
    c      = wrong_first ? c1 + 2 + int'($urandom_range(0, 3)) : c1;
    t0     = c + S;
    tfirst = t0 + 1 + d;
    tdone  = tfirst + re * we + (re - 1) * ge;
    ab     = (ab_rel < 0) ? -1 : tfirst + ab_rel;
    kend   = tdone + 2;
    if (ab >= 0 && ab + 3 > kend) kend = ab + 3;

    for (int k = 1; k <= kend; k++) begin
      step();
      live    = (ab < 0) || (k <= ab);
      e_armed = live && (k <= t0);
      e_busy  = live && (k > t0) && (k < tdone);
      e_done  = live && (k == tdone);
      e_trig  = live && (k >= tfirst) && (k < tdone) && (((k - tfirst) % (we + ge)) < we);
      chk_all(k, e_trig, e_armed, e_busy, e_done, 1'b0);

      if (k == 1) begin
        bus_if.arm = 1'b0;
        scramble_cfg();
      end
      if (k == c1) bus_if.ext_trig = ~l0;
      if (wrong_first && k == c) bus_if.ext_trig = l0;
      if (ab < 0 && k == t0 + 2) bus_if.arm = 1'b1;
      if (ab < 0 && k == t0 + 3) bus_if.arm = 1'b0;
      if (k == ab) begin
        if (use_rst) rst = 1'b1;
        else bus_if.abort = 1'b1;
      end
      if (k == ab + 1) begin
        rst          = 1'b0;
        bus_if.abort = 1'b0;
      end
    end
    bus_if.arm = 1'b0;
  endtask

  task automatic run_timeout(input int tmo);
    logic e_armed, e_to;
    bus_if.cfg_delay   = CNT_W_DEF'(1);
    bus_if.cfg_width   = PW_W_DEF'(1);
    bus_if.cfg_repeat  = REP_W_DEF'(1);
    bus_if.cfg_gap     = CNT_W_DEF'(1);
    bus_if.cfg_timeout = TO_W_DEF'(tmo);
    bus_if.edge_sel    = 1'b0;
    bus_if.arm         = 1'b1;
    for (int k = 1; k <= tmo + 5; k++) begin
      step();
      if (k == 1) bus_if.arm = 1'b0;
`ifdef GLITCH_TRIG_TIMEOUT_EN
      e_armed = (k <= tmo);
      e_to    = (k == tmo + 1);
`else
      e_armed = 1'b1;
      e_to    = 1'b0;
`endif
      chk("to_armed", k, bus_if.armed, e_armed);
      chk("to_pulse", k, bus_if.timed_out, e_to);
      chk("to_trig", k, bus_if.trig, 1'b0);
    end
    bus_if.abort = 1'b1;
    step();
    bus_if.abort = 1'b0;
    step();
    chk("to_idle_armed", 0, bus_if.armed, 1'b0);
    chk("to_idle_busy", 0, bus_if.busy, 1'b0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int d, w, r, g, ab;
    rst                = 1'b1;
    bus_if.arm         = 1'b0;
    bus_if.abort       = 1'b0;
    bus_if.ext_trig    = 1'b0;
    bus_if.edge_sel    = 1'b0;
    bus_if.cfg_delay   = '0;
    bus_if.cfg_width   = '0;
    bus_if.cfg_repeat  = '0;
    bus_if.cfg_gap     = '0;
    bus_if.cfg_timeout = '0;
    repeat (3) step();
    chk_all(-1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    step();

    run_burst(10, 1, 1, 0, 1'b0, 1'b0, -1, 1'b0, 0);
    run_burst(0, 3, 4, 2, 1'b0, 1'b0, -1, 1'b0, 0);
    run_burst(5, 0, 0, 0, 1'b0, 1'b0, -1, 1'b0, 0);
    run_burst(3, 2, 1, 1, 1'b1, 1'b1, -1, 1'b0, 0);
    run_burst(2, 3, 5, 2, 1'b0, 1'b0, 6, 1'b0, 0);
    run_burst(4, 1, 2, 1, 1'b0, 1'b0, -1, 1'b0, 0);
    run_burst(1, 2, 3, 1, 1'b1, 1'b0, 3, 1'b1, 0);
    run_burst(0, 1, 1, 0, 1'b1, 1'b0, -1, 1'b0, 1000);

    for (int i = 0; i < 14; i++) begin
      d  = int'($urandom_range(0, 12));
      w  = int'($urandom_range(0, 4));
      r  = int'($urandom_range(0, 4));
      g  = int'($urandom_range(0, 3));
      ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 20)) : -1;
      run_burst(d, w, r, g, 1'($urandom), 1'($urandom), ab, 1'($urandom),
                ($urandom_range(0, 1) == 1) ? 1000 : 0);
    end

    run_timeout(100);
    run_burst(2, 2, 2, 2, 1'b0, 1'b0, -1, 1'b0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
